// File: rtl/p16_uart_rx.sv
// 8/N/1 UART receiver: 2-flop synchroniser, mid-bit sampling FSM, one-entry valid/ready output register.
// Define UART_RX_MAJORITY_EN to take each bit as the 2-of-3 majority of the last three mid-bit samples.
module p16_uart_rx #(
    parameter int CLK_FREQ = 250000,
    parameter int BAUD     = 9600
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_in,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun
);

    // state  | meaning
    // IDLE   | line idle, waiting for a falling edge
    // START  | timing to mid start bit, rejects short low glitches
    // DATA   | sampling 8 data bits LSB-first at mid-bit
    // STOP   | sampling stop bit, delivering or flagging the byte
    // BREAK  | stop bit was low, waiting for the line to return high

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT) + 1;

    localparam logic [CW-1:0] C_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_HALF = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] C_ZERO = '0;
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          r_state;
    logic            r_sync1;
    logic            r_rx_s;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_idx;
    logic [7:0]      r_shift;
    logic [7:0]      r_data;
    logic            r_valid;
    logic            r_frame_err;
    logic            r_overrun;
    logic            w_tick;
    logic            w_bit;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= i_in;
            r_rx_s  <= r_sync1;
        end
    end

    assign w_tick = (r_cnt == C_ZERO);

`ifdef UART_RX_MAJORITY_EN
    logic r_s2;
    logic r_s1;

    // Early samples at counter 2 and 1 keep the decision point, and thus latency, at counter 0.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s2 <= 1'b1;
            r_s1 <= 1'b1;
        end else begin
            if (r_cnt == CW'(2)) r_s2 <= r_rx_s;
            if (r_cnt == C_ONE)  r_s1 <= r_rx_s;
        end
    end

    assign w_bit = (r_s2 & r_s1) | (r_s2 & r_rx_s) | (r_s1 & r_rx_s);
`else
    assign w_bit = r_rx_s;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= C_ZERO;
            r_idx       <= 3'd0;
            r_shift     <= 8'h00;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;

            // Consumer handshake; a delivery in STOP below overrides this clear.
            if (r_valid && i_ready) r_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        r_state <= S_START;
                        r_cnt   <= C_HALF;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (w_bit) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_DATA;
                            r_cnt   <= C_FULL;
                            r_idx   <= 3'd0;
                        end
                    end else begin
                        r_cnt <= r_cnt - C_ONE;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_shift <= {w_bit, r_shift[7:1]};
                        r_idx   <= r_idx + 3'd1;
                        r_cnt   <= C_FULL;
                        if (r_idx == 3'd7) r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt - C_ONE;
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        if (w_bit) begin
                            if (!r_valid || i_ready) begin
                                r_data  <= r_shift;
                                r_valid <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                            r_state <= S_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt - C_ONE;
                    end
                end
                S_BREAK: begin
                    if (r_rx_s) r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= C_ZERO;
                end
            endcase
        end
    end

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_p16_uart_rx.sv
// Scoreboard bench for p16_uart_rx at default parameters (26 clocks per bit).
module tb_p16_uart_rx;

    localparam int CPB = 26;

    logic       clk = 1'b0;
    logic       i_rst;
    logic       i_in;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;
    logic       o_frame_err;
    logic       o_overrun;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         rise_cyc = 0;
    int         valid_cycles = 0;
    int         n_ferr = 0;
    int         n_ovr = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] q[$];

    p16_uart_rx dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_in        (i_in),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!i_rst) begin
            if (o_valid && !prev_valid) rise_cyc = cyc;
            if (o_valid) valid_cycles++;
            if (o_frame_err) n_ferr++;
            if (o_overrun) n_ovr++;
            if (o_valid && i_ready) begin
                if (q.size() == 0) chk("spurious_byte", q.size(), 1);
                else chk("data", int'(o_data), int'(q.pop_front()));
            end
            prev_valid = o_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    // Called and returns at posedge+1. Value set at step c is captured by the synchroniser at the next edge.
    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit glitch, input int rst_at);
        int  bi;
        logic v;
        for (int c = 0; c < 10 * CPB; c++) begin
            bi = c / CPB;
            if (bi == 0)      v = 1'b0;
            else if (bi <= 8) v = b[bi-1];
            else              v = stop_ok;
            if (glitch && bi >= 1 && bi <= 8 && (c % CPB) == 13) v = ~v;
            i_in = v;
            if (rst_at >= 0 && c == rst_at) begin
                i_rst = 1'b1;
                #1;
                chk("rst_valid", int'(o_valid), 0);
                chk("rst_data", int'(o_data), 0);
                chk("rst_ferr", int'(o_frame_err), 0);
                chk("rst_ovr", int'(o_overrun), 0);
            end
            if (rst_at >= 0 && c == rst_at + 3) i_rst = 1'b0;
            @(posedge clk); #1;
        end
        i_in = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk("drain", q.size(), 0);
    endtask

    int t0, lat, v0, f0, o0;

    initial begin
        i_rst   = 1'b1;
        i_in    = 1'b1;
        i_ready = 1'b1;
        #2;
        chk("reset_valid", int'(o_valid), 0);
        chk("reset_data", int'(o_data), 0);
        chk("reset_ferr", int'(o_frame_err), 0);
        chk("reset_ovr", int'(o_overrun), 0);
        idle(3);
        i_rst = 1'b0;
        idle(10);

        // Basic byte with latency and single-cycle valid
        v0 = valid_cycles; f0 = n_ferr; o0 = n_ovr;
        t0 = cyc;
        q.push_back(8'hA5);
        send_byte(8'hA5, 1'b1, 1'b0, -1);
        wait_drain();
        idle(5);
        lat = rise_cyc - t0;
        chk("latency", (lat >= 249 && lat <= 251) ? 250 : lat, 250);
        chk("valid_width", valid_cycles - v0, 1);
        chk("a5_ferr", n_ferr - f0, 0);
        chk("a5_ovr", n_ovr - o0, 0);

        // False start
        v0 = valid_cycles; f0 = n_ferr;
        i_in = 1'b0;
        idle(5);
        i_in = 1'b1;
        idle(40);
        chk("false_start_valid", valid_cycles - v0, 0);
        chk("false_start_ferr", n_ferr - f0, 0);
        q.push_back(8'h3C);
        send_byte(8'h3C, 1'b1, 1'b0, -1);
        wait_drain();
        idle(5);

        // Framing error with held-low line
        v0 = valid_cycles; f0 = n_ferr;
        send_byte(8'h3C, 1'b0, 1'b0, -1);
        i_in = 1'b0;
        idle(100);
        i_in = 1'b1;
        idle(30);
        chk("ferr_pulses", n_ferr - f0, 1);
        chk("ferr_no_valid", valid_cycles - v0, 0);
        q.push_back(8'h81);
        send_byte(8'h81, 1'b1, 1'b0, -1);
        wait_drain();
        idle(5);

        // Overrun
        o0 = n_ovr;
        i_ready = 1'b0;
        q.push_back(8'h11);
        send_byte(8'h11, 1'b1, 1'b0, -1);
        send_byte(8'h22, 1'b1, 1'b0, -1);
        idle(5);
        chk("ovr_pulses", n_ovr - o0, 1);
        chk("ovr_held_valid", int'(o_valid), 1);
        chk("ovr_held_data", int'(o_data), 8'h11);
        i_ready = 1'b1;
        idle(2);
        chk("ovr_valid_drop", int'(o_valid), 0);
        chk("ovr_queue", q.size(), 0);
        idle(5);

        // Reset during the 4th data bit
        v0 = valid_cycles; f0 = n_ferr; o0 = n_ovr;
        send_byte(8'hFF, 1'b1, 1'b0, 4 * CPB + 5);
        idle(20);
        chk("rst_no_valid", valid_cycles - v0, 0);
        chk("rst_no_ferr", n_ferr - f0, 0);
        chk("rst_no_ovr", n_ovr - o0, 0);
        q.push_back(8'h5A);
        send_byte(8'h5A, 1'b1, 1'b0, -1);
        wait_drain();
        idle(5);

        // Mid-bit glitches on every data bit
`ifdef UART_RX_MAJORITY_EN
        q.push_back(8'h96);
`else
        q.push_back(8'h69);
`endif
        send_byte(8'h96, 1'b1, 1'b1, -1);
        wait_drain();
        idle(10);
        chk("final_valid", int'(o_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
